// File: rtl/skynet_mac_pipe_if.sv
// Beat-level bus of the SkyNet MAC pipe.
//   Input side : in_valid/in_ready handshake, operands din0/din1, in_mode (0 multiply,
//                1 accumulate), in_first/in_last group delimiters.
//   Output side: out_valid/out_ready handshake, dout (product or group sum), out_ovf.
// master = producer/consumer around the unit, slave = the MAC unit itself.
interface skynet_mac_pipe_if #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 13,
  parameter int unsigned ACC_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   din0;
  logic [B_WIDTH-1:0]   din1;
  logic                 in_mode;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] dout;
  logic                 out_ovf;

  modport master (
    output in_valid, din0, din1, in_mode, in_first, in_last, out_ready,
    input  in_ready, out_valid, dout, out_ovf
  );

  modport slave (
    input  in_valid, din0, din1, in_mode, in_first, in_last, out_ready,
    output in_ready, out_valid, dout, out_ovf
  );
endinterface

// File: rtl/skynet_mac_pipe.sv
// Pipelined multiply-accumulate unit with valid/ready flow control.
// Ports:
//   ap_clk - clock, all state on rising edge
//   ap_rst - synchronous active-high reset
//   bus    - skynet_mac_pipe_if slave: input beats (operands + mode/first/last) and
//            output words (dout + out_ovf) with valid/ready on both sides.
// Pipeline: input capture register, NUM_STAGE product registers, then the
// accumulate/output register. The whole pipe advances together on en.
module skynet_mac_pipe #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 13,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned NUM_STAGE = 2,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned SATURATE  = 1
) (
  input logic              ap_clk,
  input logic              ap_rst,
  skynet_mac_pipe_if.slave bus
);
  localparam int unsigned P   = A_WIDTH + B_WIDTH;
  localparam int unsigned MSB = ACC_WIDTH - 1;

  logic en;

  // Input capture stage
  logic               in_v_q, in_m_q, in_f_q, in_l_q;
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;

  // Product stages; index 0 is the youngest
  logic [NUM_STAGE-1:0][P-1:0] prod_q;
  logic [NUM_STAGE-1:0]        v_q, m_q, f_q, l_q;

  // Accumulator and output register
  logic [ACC_WIDTH-1:0] acc_q, dout_q;
  logic                 sticky_q, ovf_q, out_valid_q;

  // Combinational helpers
  logic [P-1:0]         a_x, b_x, prod;
  logic [P-1:0]         p_last;
  logic                 v_last, m_last, f_last, l_last;
  logic [ACC_WIDTH-1:0] prod_acc, base, raw, sat, sum;
  logic [ACC_WIDTH:0]   sum_full;
  logic                 add_ovf, sticky_new;

  assign en            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_ovf   = ovf_q;

  // Operands extended to P bits (sign or zero); the low P bits of the P x P product
  // equal the exact signed/unsigned product since it always fits in P bits.
  always_comb begin
    a_x              = {P{(SIGNED != 0) && a_q[A_WIDTH-1]}};
    a_x[A_WIDTH-1:0] = a_q;
    b_x              = {P{(SIGNED != 0) && b_q[B_WIDTH-1]}};
    b_x[B_WIDTH-1:0] = b_q;
    prod             = a_x * b_x;
  end

  assign p_last = prod_q[NUM_STAGE-1];
  assign v_last = v_q[NUM_STAGE-1];
  assign m_last = m_q[NUM_STAGE-1];
  assign f_last = f_q[NUM_STAGE-1];
  assign l_last = l_q[NUM_STAGE-1];

  always_comb begin
    prod_acc        = {ACC_WIDTH{(SIGNED != 0) && p_last[P-1]}};
    prod_acc[P-1:0] = p_last;
    // A first beat restarts from zero, so the product alone can never overflow.
    base            = f_last ? '0 : acc_q;
    sum_full        = {1'b0, base} + {1'b0, prod_acc};
    raw             = sum_full[ACC_WIDTH-1:0];
    if (SIGNED != 0) begin
      add_ovf = (base[MSB] == prod_acc[MSB]) && (raw[MSB] != base[MSB]);
      // On signed overflow both addends share a sign; clamp toward it.
      sat     = prod_acc[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      add_ovf = sum_full[ACC_WIDTH];
      sat     = '1;
    end
    sum        = (add_ovf && (SATURATE != 0)) ? sat : raw;
    sticky_new = (f_last ? 1'b0 : sticky_q) | add_ovf;
  end

  // Input and product stages
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      in_v_q <= 1'b0;
      in_m_q <= 1'b0;
      in_f_q <= 1'b0;
      in_l_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      v_q    <= '0;
      m_q    <= '0;
      f_q    <= '0;
      l_q    <= '0;
    end else if (en) begin
      in_v_q <= bus.in_valid;
      in_m_q <= bus.in_mode;
      in_f_q <= bus.in_first;
      in_l_q <= bus.in_last;
      a_q    <= bus.din0;
      b_q    <= bus.din1;
      // Shift-in at index 0; the cast drops the oldest entry.
      prod_q <= (NUM_STAGE * P)'({prod_q, prod});
      v_q    <= (NUM_STAGE)'({v_q, in_v_q});
      m_q    <= (NUM_STAGE)'({m_q, in_m_q});
      f_q    <= (NUM_STAGE)'({f_q, in_f_q});
      l_q    <= (NUM_STAGE)'({l_q, in_l_q});
    end
  end

  // Accumulate / output stage
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      // en implies any held word was consumed this edge
      out_valid_q <= 1'b0;
      if (v_last) begin
        if (!m_last) begin
          dout_q      <= prod_acc;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
        end else if (l_last) begin
          dout_q      <= sum;
          ovf_q       <= sticky_new;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          sticky_q    <= 1'b0;
        end else begin
          acc_q    <= sum;
          sticky_q <= sticky_new;
        end
      end
    end
  end
endmodule

// File: tb/tb_skynet_mac_pipe.sv
module tb_skynet_mac_pipe;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  skynet_mac_pipe_if #(.A_WIDTH(8), .B_WIDTH(13), .ACC_WIDTH(32)) bu ();
  skynet_mac_pipe_if #(.A_WIDTH(8), .B_WIDTH(13), .ACC_WIDTH(21)) bs ();

  skynet_mac_pipe #(
    .A_WIDTH(8), .B_WIDTH(13), .ACC_WIDTH(32), .NUM_STAGE(2), .SIGNED(0), .SATURATE(1)
  ) dut_u (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bu)
  );

  skynet_mac_pipe #(
    .A_WIDTH(8), .B_WIDTH(13), .ACC_WIDTH(21), .NUM_STAGE(2), .SIGNED(1), .SATURATE(1)
  ) dut_s (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bs)
  );

  typedef struct {
    logic [31:0] d;
    logic        o;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [12:0] b;
    logic        m;
    logic        f;
    logic        l;
    logic        emit;
    logic [31:0] d;
    logic        o;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t qu[$];
  exp_t qs[$];
  exp_t eu, es;
  vec_t tv[11];
  logic [31:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output scoreboards: a handshake seen at a negedge completes at the next posedge.
  always @(negedge ap_clk) begin
    if (!ap_rst && bu.out_valid && bu.out_ready) begin
      if (qu.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u_unexpected: got dout=%0d expected no output", bu.dout);
      end else begin
        eu = qu.pop_front();
        check("u_dout", bu.dout, eu.d);
        check("u_ovf", bu.out_ovf, eu.o);
      end
    end
  end

  always @(negedge ap_clk) begin
    if (!ap_rst && bs.out_valid && bs.out_ready) begin
      if (qs.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s_unexpected: got dout=%0d expected no output", bs.dout);
      end else begin
        es = qs.pop_front();
        check("s_dout", bs.dout, es.d);
        check("s_ovf", bs.out_ovf, es.o);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic send(input bit s, input logic [7:0] a, input logic [12:0] b,
                      input logic m, input logic f, input logic l);
    bit ok = 1'b0;
    if (s) begin
      bs.in_valid = 1'b1; bs.din0 = a; bs.din1 = b;
      bs.in_mode = m; bs.in_first = f; bs.in_last = l;
    end else begin
      bu.in_valid = 1'b1; bu.din0 = a; bu.din1 = b;
      bu.in_mode = m; bu.in_first = f; bu.in_last = l;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      if (s ? bs.in_ready : bu.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge ap_clk);
    #1;
    if (s) bs.in_valid = 1'b0;
    else   bu.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((qu.size() != 0 || qs.size() != 0) && n < 100) begin
      @(posedge ap_clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", qu.size() + qs.size());
    end
    repeat (6) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bu.in_valid = 1'b0; bu.din0 = '0; bu.din1 = '0; bu.in_mode = 1'b0;
    bu.in_first = 1'b0; bu.in_last = 1'b0; bu.out_ready = 1'b1;
    bs.in_valid = 1'b0; bs.din0 = '0; bs.din1 = '0; bs.in_mode = 1'b0;
    bs.in_first = 1'b0; bs.in_last = 1'b0; bs.out_ready = 1'b1;

    //            a       b         m     f     l     emit  d               o
    tv[0]  = '{8'd1,   13'd2,    1'b1, 1'b1, 1'b0, 1'b0, 32'd0,       1'b0};
    tv[1]  = '{8'd3,   13'd4,    1'b1, 1'b0, 1'b0, 1'b0, 32'd0,       1'b0};
    tv[2]  = '{8'd5,   13'd6,    1'b1, 1'b0, 1'b0, 1'b0, 32'd0,       1'b0};
    tv[3]  = '{8'd7,   13'd8,    1'b1, 1'b0, 1'b1, 1'b1, 32'd100,     1'b0};
    tv[4]  = '{8'd255, 13'd8191, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2088705, 1'b0};
    tv[5]  = '{8'd1,   13'd1,    1'b1, 1'b1, 1'b0, 1'b0, 32'd0,       1'b0};
    tv[6]  = '{8'd10,  13'd10,   1'b0, 1'b0, 1'b0, 1'b1, 32'd100,     1'b0};
    tv[7]  = '{8'd2,   13'd2,    1'b1, 1'b0, 1'b1, 1'b1, 32'd5,       1'b0};
    tv[8]  = '{8'd9,   13'd9,    1'b1, 1'b1, 1'b1, 1'b1, 32'd81,      1'b0};
    tv[9]  = '{8'd0,   13'd0,    1'b0, 1'b1, 1'b1, 1'b1, 32'd0,       1'b0};
    tv[10] = '{8'd200, 13'd100,  1'b1, 1'b0, 1'b1, 1'b1, 32'd20000,   1'b0};

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_out_valid", bu.out_valid, 0);
    check("rst_dout", bu.dout, 0);
    check("rst_out_ovf", bu.out_ovf, 0);
    check("rst_in_ready", bu.in_ready, 1);
    check("rst_s_out_valid", bs.out_valid, 0);
    @(posedge ap_clk);
    #1;

    // Mode 0 latency: accepted at edge k, visible only after edge k+3
    qu.push_back('{d: 32'd2088705, o: 1'b0});
    bu.in_valid = 1'b1; bu.din0 = 8'd255; bu.din1 = 13'd8191;
    bu.in_mode = 1'b0; bu.in_first = 1'b0; bu.in_last = 1'b0;
    @(negedge ap_clk);
    check("lat_in_ready", bu.in_ready, 1);
    @(posedge ap_clk);
    #1 bu.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge ap_clk);
      check($sformatf("lat_valid_c%0d", c), bu.out_valid, (c == 4) ? 1 : 0);
    end
    drain();

    // Table: groups, interleaved mode 0, first+last, last without first
    for (int i = 0; i < 11; i++) begin
      if (tv[i].emit) qu.push_back('{d: tv[i].d, o: tv[i].o});
      send(1'b0, tv[i].a, tv[i].b, tv[i].m, tv[i].f, tv[i].l);
    end
    drain();

    // Signed saturation, both directions, then a clean group and a negative product
    qs.push_back('{d: 32'd1048575, o: 1'b1});
    send(1'b1, 8'd127, 13'd4095, 1'b1, 1'b1, 1'b0);
    send(1'b1, 8'd127, 13'd4095, 1'b1, 1'b0, 1'b0);
    send(1'b1, 8'd127, 13'd4095, 1'b1, 1'b0, 1'b1);
    qs.push_back('{d: 32'd1, o: 1'b0});
    send(1'b1, 8'd1, 13'd1, 1'b1, 1'b1, 1'b1);
    qs.push_back('{d: 32'd1048576, o: 1'b1});
    send(1'b1, 8'h80, 13'd4095, 1'b1, 1'b1, 1'b0);
    send(1'b1, 8'h80, 13'd4095, 1'b1, 1'b0, 1'b0);
    send(1'b1, 8'h80, 13'd4095, 1'b1, 1'b0, 1'b1);
    qs.push_back('{d: 32'd2097147, o: 1'b0});
    send(1'b1, 8'hFF, 13'd5, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: 5-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          qu.push_back('{d: 32'((i + 1) * (i + 3)), o: 1'b0});
          send(1'b0, 8'(i + 1), 13'(i + 3), 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (5) @(posedge ap_clk);
        #1 bu.out_ready = 1'b0;
        @(negedge ap_clk);
        held = bu.dout;
        check("bp_out_valid", bu.out_valid, 1);
        check("bp_in_ready_0", bu.in_ready, 0);
        for (int c = 1; c < 5; c++) begin
          @(negedge ap_clk);
          check($sformatf("bp_in_ready_%0d", c), bu.in_ready, 0);
          check($sformatf("bp_dout_hold_%0d", c), bu.dout, held);
        end
        @(posedge ap_clk);
        #1 bu.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-group: partial sum (1) reached acc, beat 2 still in flight
    send(1'b0, 8'd1, 13'd1, 1'b1, 1'b1, 1'b0);
    send(1'b0, 8'd2, 13'd2, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_out_valid", bu.out_valid, 0);
    check("mid_rst_in_ready", bu.in_ready, 1);
    @(posedge ap_clk);
    #1;
    qu.push_back('{d: 32'd26, o: 1'b0});
    send(1'b0, 8'd2, 13'd3, 1'b1, 1'b0, 1'b0);
    send(1'b0, 8'd4, 13'd5, 1'b1, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
